// File: rtl/fc_argmax_reader.sv
// Dense classifier head: reads conv-3 activations from temp RAM, computes
// OUT_LEN dot products plus bias, and reports the argmax class and its score.
module fc_argmax_reader #(
  parameter int unsigned IN_LEN    = 60,
  parameter int unsigned OUT_LEN   = 10,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic [13:0] temp_addr,
  input  logic [31:0] temp_q,
  output logic [13:0] weight_addr,
  input  logic [31:0] curweight,
  output logic [9:0]  bias_addr,
  input  logic [31:0] curbias,
  output logic [3:0]  digit,
  output logic [31:0] score,
  output logic        busy,
  output logic        ready
);

  localparam int unsigned AW  = 14;
  localparam int unsigned BW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 2 * DW;
  localparam int unsigned JW  = 4;

  localparam logic [AW-1:0] I_LAST = AW'(IN_LEN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BIAS_ADDR  = 3'd1,
    BIAS_LATCH = 3'd2,
    MAC_ADDR   = 3'd3,
    MAC_ACC    = 3'd4,
    COMPARE    = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic signed [DW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  best_q, best_d;
  logic [JW-1:0]         win_q, win_d;
  logic [JW-1:0]         digit_q, digit_d;
  logic [DW-1:0]         score_q, score_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic signed [PW-1:0]  prod_c;
  logic signed [DW-1:0]  term_c;
  logic                  take_c;

  // Full-width signed product, rescaled and truncated to the accumulator width
  always_comb begin
    prod_c = PW'($signed(temp_q)) * PW'($signed(curweight));
    term_c = DW'(prod_c >>> FRAC_BITS);
  end

  // Read addresses decode straight from the counters so they stay stable across states
  always_comb begin
    temp_addr   = i_q;
    weight_addr = AW'(32'(j_q) * 32'(IN_LEN) + 32'(i_q));
    bias_addr   = BW'(j_q);
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    best_d  = best_q;
    win_d   = win_q;
    digit_d = digit_q;
    score_d = score_q;
    take_c  = (j_q == '0) || (acc_q > best_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          j_d     = '0;
          state_d = BIAS_ADDR;
        end
      end
      BIAS_ADDR: begin
        state_d = BIAS_LATCH;
      end
      BIAS_LATCH: begin
        acc_d   = $signed(curbias);
        i_d     = '0;
        state_d = MAC_ADDR;
      end
      MAC_ADDR: begin
        state_d = MAC_ACC;
      end
      MAC_ACC: begin
        acc_d = acc_q + term_c;
        if (i_q == I_LAST) begin
          state_d = COMPARE;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = MAC_ADDR;
        end
      end
      COMPARE: begin
        if (take_c) begin
          best_d = acc_q;
          win_d  = j_q;
        end
        if (j_q == J_LAST) begin
          // Publish the final result together with the ready pulse
          digit_d = take_c ? j_q : win_q;
          score_d = take_c ? acc_q : best_q;
          state_d = DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = BIAS_ADDR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      best_q  <= '0;
      win_q   <= '0;
      digit_q <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      win_q   <= win_d;
      digit_q <= digit_d;
      score_q <= score_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign digit = digit_q;
  assign score = score_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Directed bench for fc_argmax_reader: classification results, latency,
// tie/sign handling, mid-run reset, ignored starts and address sequencing.
module tb_fc_argmax_reader;

  logic        Clk = 1'b0;
  logic        rst0, rst16;
  logic        start0, start16;

  logic [13:0] taddr0, waddr0, taddr16, waddr16;
  logic [9:0]  baddr0, baddr16;
  logic [31:0] tq0, wq0, bq0, tq16, wq16, bq16;
  logic [3:0]  digit0, digit16;
  logic [31:0] score0, score16;
  logic        busy0, busy16, ready0, ready16;

  logic [31:0] tmem [0:16383];
  logic [31:0] wmem [0:16383];
  logic [31:0] bmem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fc_argmax_reader #(.IN_LEN(60), .OUT_LEN(10), .FRAC_BITS(0)) dut0 (
    .Clk(Clk), .Reset(rst0), .start(start0),
    .temp_addr(taddr0), .temp_q(tq0),
    .weight_addr(waddr0), .curweight(wq0),
    .bias_addr(baddr0), .curbias(bq0),
    .digit(digit0), .score(score0), .busy(busy0), .ready(ready0)
  );

  fc_argmax_reader #(.IN_LEN(60), .OUT_LEN(10), .FRAC_BITS(16)) dut16 (
    .Clk(Clk), .Reset(rst16), .start(start16),
    .temp_addr(taddr16), .temp_q(tq16),
    .weight_addr(waddr16), .curweight(wq16),
    .bias_addr(baddr16), .curbias(bq16),
    .digit(digit16), .score(score16), .busy(busy16), .ready(ready16)
  );

  // Synchronous RAM/ROM models with one-cycle read latency
  always @(posedge Clk) begin
    tq0  <= tmem[taddr0];
    wq0  <= wmem[waddr0];
    bq0  <= bmem[baddr0];
    tq16 <= tmem[taddr16];
    wq16 <= wmem[waddr16];
    bq16 <= bmem[baddr16];
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] tval, input int wmode, input logic [31:0] bval);
    for (int a = 0; a < 16384; a++) begin
      tmem[a] = tval;
      wmem[a] = 32'd0;
    end
    for (int a = 0; a < 1024; a++) bmem[a] = bval;
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 60; i++) begin
        if (wmode == 1) wmem[j*60+i] = 32'(j);
        if (wmode == 2 && j == 3) wmem[j*60+i] = 32'h0000_8000;
      end
    end
  endtask

  // One classification on dut0; optional timing, address, mid-run start and reset checks
  task automatic run0(input string tag, input int reset_at, input bit timing, input bit extra,
                      input logic [3:0] exp_digit, input logic [31:0] exp_score);
    int  ready_cnt;
    bit  aborted;
    int  jj, oo, mm;
    ready_cnt = 0;
    aborted   = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    if (timing) chk({tag, "_busy_k0"}, 32'(busy0), 32'd1);
    if (extra) chk({tag, "_bias_addr_k0"}, 32'(baddr0), 32'd0);
    for (int k = 1; k <= 1240 && !aborted; k++) begin
      start0 = extra && (k == 10 || k == 600);
      rst0   = (k == reset_at);
      tick();
      start0 = 1'b0;
      if (k == reset_at) begin
        rst0 = 1'b0;
        chk({tag, "_rst_busy"},  32'(busy0),  32'd0);
        chk({tag, "_rst_ready"}, 32'(ready0), 32'd0);
        chk({tag, "_rst_digit"}, 32'(digit0), 32'd0);
        chk({tag, "_rst_score"}, score0,      32'd0);
        chk({tag, "_rst_waddr"}, 32'(waddr0), 32'd0);
        aborted = 1'b1;
      end else begin
        if (ready0) ready_cnt++;
        if (timing && k <= 1231) begin
          chk({tag, "_busy"},  32'(busy0),  (k <= 1230) ? 32'd1 : 32'd0);
          chk({tag, "_ready"}, 32'(ready0), (k == 1230) ? 32'd1 : 32'd0);
        end
        if (extra && k < 1230) begin
          jj = k / 123;
          oo = k % 123;
          if (oo == 0) chk({tag, "_bias_addr"}, 32'(baddr0), 32'(jj));
          if (oo >= 2 && oo <= 121) begin
            mm = (oo - 2) / 2;
            chk({tag, "_temp_addr"},   32'(taddr0), 32'(mm));
            chk({tag, "_weight_addr"}, 32'(waddr0), 32'(jj * 60 + mm));
          end
        end
      end
    end
    if (!aborted) begin
      chk({tag, "_ready_pulses"}, 32'(ready_cnt), 32'd1);
      chk({tag, "_busy_end"},     32'(busy0),     32'd0);
      chk({tag, "_digit"},        32'(digit0),    32'(exp_digit));
      chk({tag, "_score"},        score0,         exp_score);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst16 = 1'b1; start0 = 1'b0; start16 = 1'b0;
    fill(32'd1, 1, 32'd0);
    tick();
    tick();
    rst0 = 1'b0; rst16 = 1'b0;
    tick();

    // Reset state
    chk("reset_digit", 32'(digit0), 32'd0);
    chk("reset_score", score0,      32'd0);
    chk("reset_busy",  32'(busy0),  32'd0);
    chk("reset_ready", 32'(ready0), 32'd0);
    chk("reset_taddr", 32'(taddr0), 32'd0);
    chk("reset_waddr", 32'(waddr0), 32'd0);
    chk("reset_baddr", 32'(baddr0), 32'd0);
    chk("reset16_busy", 32'(busy16), 32'd0);

    // Weight j everywhere: class 9 scores 9*60
    run0("t1", -1, 1'b1, 1'b0, 4'd9, 32'd540);

    // Equal biases, zero weights: lowest index wins the tie
    fill(32'd1, 0, 32'd5);
    run0("t2", -1, 1'b0, 1'b0, 4'd0, 32'd5);

    // Negative scores: -1 must beat -50 under signed compare
    fill(32'd1, 0, 32'hFFFF_FFCE);
    bmem[7] = 32'hFFFF_FFFF;
    run0("t3", -1, 1'b0, 1'b0, 4'd7, 32'hFFFF_FFFF);

    // Reset mid-run clears everything, then a fresh run gives the full result
    fill(32'd1, 1, 32'd0);
    run0("t5a", 500, 1'b0, 1'b0, 4'd0, 32'd0);
    run0("t5b", -1, 1'b0, 1'b0, 4'd9, 32'd540);

    // Starts during a run are ignored; address sequencing checked every cycle
    run0("t6", -1, 1'b0, 1'b1, 4'd9, 32'd540);

    // Q16 fixed point: 1.0 * 0.5 summed 60 times in class 3
    fill(32'h0001_0000, 2, 32'd0);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (1229) tick();
    chk("t4_ready_before", 32'(ready16), 32'd0);
    tick();
    chk("t4_ready", 32'(ready16), 32'd1);
    tick();
    chk("t4_busy_end", 32'(busy16), 32'd0);
    chk("t4_digit", 32'(digit16), 32'd3);
    chk("t4_score", score16, 32'h001E_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
